// File: rtl/spi_chain_master_pkg.sv
// Shared definitions for the miner daisy-chain SPI initiator: FSM encodings,
// frame geometry and the command-to-frame packing helper.
package spi_master_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam int         FRAME_BITS     = 24;
  localparam logic [6:0] BROADCAST_ADDR = 7'h7F;
  localparam logic       RW_READ        = 1'b1;

  // Reads send a zero data byte; the chain drives byte 2 back on MISO.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic       write,
                                                        input logic [6:0] addr,
                                                        input logic [7:0] reg_addr,
                                                        input logic [7:0] data);
    return {~write, addr, reg_addr, (write ? data : 8'h00)};
  endfunction

endpackage

// File: rtl/spi_chain_master_if.sv
// Command/response handshake between the host logic and spi_chain_master.
interface spi_chain_master_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_reg, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_reg, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/spi_chain_master_sclk_gen.sv
// SCLK divider: CLK_DIV iCLK cycles per half-period, starting low when enabled.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic iCLK,
  input  logic RSTin,
  input  logic enable,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] cnt;
  logic             wrap;

  // Ticks mark the iCLK edge on which sclk changes level.
  assign wrap      = enable && (cnt == DIV_W'(CLK_DIV - 1));
  assign rise_tick = wrap && !sclk;
  assign fall_tick = wrap && sclk;

  always_ff @(posedge iCLK or negedge RSTin) begin
    if (!RSTin) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_chain_master.sv
// Host-side SPI mode-0 initiator for the miner chain: 24-bit frames, MSB first.
// Optional IRQ capture logic is enabled by defining SPI_MASTER_IRQ_EN.
module spi_chain_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic               iCLK,
  input  logic               RSTin,
  input  logic               id_enable,
  spi_chain_master_if.slave  cmd,
  output logic               SCLKout,
  output logic               SCSNout,
  output logic               MOSIout,
  input  logic               MISOin,
  output logic               IDout
`ifdef SPI_MASTER_IRQ_EN
  ,
  input  logic               IRQin,
  input  logic               irq_clear,
  output logic               irq_pending
`endif
);

  logic [2:0]            state, state_nxt;
  logic [7:0]            tmr;
  logic                  tmr_done;
  logic [4:0]            bit_cnt;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [7:0]            rx_sr;
  logic                  rw_q;
  logic                  busy;
  logic                  rise_tick, fall_tick;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .iCLK      (iCLK),
    .RSTin     (RSTin),
    .enable    (state == ST_SHIFT),
    .sclk      (SCLKout),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Pins decode straight from state so an async reset idles them immediately.
  assign busy    = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
  assign SCSNout = ~busy;
  assign MOSIout = busy & tx_sr[FRAME_BITS-1];

  always_comb begin
    tmr_done = 1'b0;
    case (state)
      ST_SETUP: tmr_done = (tmr == 8'(CS_SETUP - 1));
      ST_HOLD:  tmr_done = (tmr == 8'(CS_HOLD - 1));
      ST_GAP:   tmr_done = (tmr == 8'(CS_GAP - 1));
      default:  tmr_done = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd.cmd_valid && cmd.cmd_ready) state_nxt = ST_SETUP;
      ST_SETUP: if (tmr_done) state_nxt = ST_SHIFT;
      ST_SHIFT: if (fall_tick && (bit_cnt == 5'(FRAME_BITS - 1))) state_nxt = ST_HOLD;
      ST_HOLD:  if (tmr_done) state_nxt = ST_GAP;
      ST_GAP:   if (tmr_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge RSTin) begin
    if (!RSTin) begin
      state         <= ST_IDLE;
      tmr           <= '0;
      bit_cnt       <= '0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      rw_q          <= 1'b0;
      cmd.cmd_ready <= 1'b0;
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_rdata <= '0;
      IDout         <= 1'b0;
    end else begin
      state         <= state_nxt;
      tmr           <= (state_nxt != state) ? 8'd0 : tmr + 8'd1;
      cmd.cmd_ready <= (state_nxt == ST_IDLE);
      cmd.rsp_valid <= (state == ST_HOLD) && (state_nxt == ST_GAP);
      IDout         <= id_enable;
      case (state)
        ST_IDLE: begin
          if (cmd.cmd_valid && cmd.cmd_ready) begin
            tx_sr   <= build_frame(cmd.cmd_write, cmd.cmd_addr, cmd.cmd_reg, cmd.cmd_wdata);
            rw_q    <= ~cmd.cmd_write;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (rise_tick) rx_sr <= {rx_sr[6:0], MISOin};
          if (fall_tick) begin
            tx_sr <= tx_sr << 1;
            if (bit_cnt != 5'(FRAME_BITS - 1)) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        // The last eight sampled bits are byte 2 of the frame.
        ST_HOLD: begin
          if (tmr_done) cmd.rsp_rdata <= (rw_q == RW_READ) ? rx_sr : 8'h00;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_MASTER_IRQ_EN
  logic [1:0] irq_sync;
  logic       irq_prev;

  // Set on a synchronized rising edge takes priority over a clear.
  always_ff @(posedge iCLK or negedge RSTin) begin
    if (!RSTin) begin
      irq_sync    <= '0;
      irq_prev    <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      irq_sync <= {irq_sync[0], IRQin};
      irq_prev <= irq_sync[1];
      if (irq_sync[1] && !irq_prev) irq_pending <= 1'b1;
      else if (irq_clear)          irq_pending <= 1'b0;
    end
  end
`endif

endmodule
